// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit slots, tear-free shadow capture,
// guard-band anode blanking. Define SEG_LZB_EN to compile in leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_DIGITS*4-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic [7:0]              seg_cat,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    logic [PW-1:0]           presc_p0;
    logic [IW-1:0]           idx_p0;
    logic [NUM_DIGITS*4-1:0] shadow_val_p0;
    logic [NUM_DIGITS-1:0]   shadow_dp_p0;

    logic [NUM_DIGITS-1:0]   an_p1;
    logic [7:0]              cat_p1;
    logic                    frame_tick_p1;

    logic                    slot_tick;
    logic                    wrap_tick;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              cat_next;

    assign slot_tick = (presc_p0 == PW'(REFRESH_DIV - 1));
    assign wrap_tick = slot_tick && (idx_p0 == IW'(NUM_DIGITS - 1));
    assign cur_nib   = shadow_val_p0[{idx_p0, 2'b00} +: 4];
    assign cur_dp    = shadow_dp_p0[idx_p0];

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lz_from;
    logic [NUM_DIGITS-1:0] blank_mask;

    // lz_from[k]: every shadow nibble from k up to the most significant digit is zero.
    always_comb begin
        lz_from    = '0;
        blank_mask = '0;
        lz_from[NUM_DIGITS-1] = (shadow_val_p0[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            lz_from[k] = lz_from[k+1] && (shadow_val_p0[4*k +: 4] == 4'h0);
        end
        for (int k = 1; k < NUM_DIGITS; k++) begin
            blank_mask[k] = lz_from[k] && !shadow_dp_p0[k];
        end
    end

    assign blank = blank_mask[idx_p0];
`else
    assign blank = 1'b0;
`endif

    assign an_next  = ((presc_p0 < PW'(GUARD_CYCLES)) || !en || blank)
                      ? '1 : ~(NUM_DIGITS'(1) << idx_p0);
    assign cat_next = {~cur_dp, seg_decode(cur_nib)};

    // Stage p0: prescaler, digit index and shadow capture on the wrapping slot tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_p0      <= '0;
            idx_p0        <= '0;
            shadow_val_p0 <= '0;
            shadow_dp_p0  <= '0;
        end else begin
            presc_p0 <= slot_tick ? '0 : presc_p0 + PW'(1);
            if (slot_tick) begin
                idx_p0 <= (idx_p0 == IW'(NUM_DIGITS - 1)) ? '0 : idx_p0 + IW'(1);
            end
            if (wrap_tick) begin
                shadow_val_p0 <= value_in;
                shadow_dp_p0  <= dp_in;
            end
        end
    end

    // Stage p1: registered pad drive, one cycle behind the p0 state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_p1         <= '1;
            cat_p1        <= 8'hFF;
            frame_tick_p1 <= 1'b0;
        end else begin
            an_p1         <= an_next;
            cat_p1        <= cat_next;
            frame_tick_p1 <= wrap_tick;
        end
    end

    assign seg_an     = an_p1;
    assign seg_cat    = cat_p1;
    assign frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  seg_an;
    logic [7:0]  seg_cat;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

`ifdef SEG_LZB_EN
    localparam logic [3:0] LIT_0005    = 4'b0001;
    localparam logic [3:0] LIT_0005_DP = 4'b0101;
`else
    localparam logic [3:0] LIT_0005    = 4'b1111;
    localparam logic [3:0] LIT_0005_DP = 4'b1111;
`endif

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // k counts samples from the first cycle after frame_tick; each slot is 8 samples, 2 dark.
    function automatic logic [3:0] exp_an(input int k, input logic [3:0] lit);
        int s;
        s = (k / 8) % 4;
        if ((k % 8) < 2 || !lit[s]) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [7:0] exp_cat(input logic [15:0] v, input logic [3:0] dp, input int k);
        int s;
        s = (k / 8) % 4;
        return {~dp[s], pat(v[4*s +: 4])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (frame_tick === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b1; en = 1'b1; value_in = 16'h1234; dp_in = 4'b0000;
        tick(); tick();
        checks++; if (seg_an !== 4'hF) begin errors++; $display("FAIL rst_an got %h exp F", seg_an); end
        checks++; if (seg_cat !== 8'hFF) begin errors++; $display("FAIL rst_cat got %h exp FF", seg_cat); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_ft got %b exp 0", frame_tick); end
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 3) begin
                checks++; if (seg_an !== 4'hE) begin errors++; $display("FAIL rst_first_an got %b exp 1110", seg_an); end
                checks++; if (seg_cat !== 8'hC0) begin errors++; $display("FAIL rst_shadow_cat got %h exp C0", seg_cat); end
            end
            if (frame_tick === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++;
        if (first + 1 != 33) begin errors++; $display("FAIL rst_first_ft cycle got %0d exp 33", first + 1); end
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = exp_an(k, 4'hF);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'h1234, 4'b0000, k)) begin
                    errors++; $display("FAIL scan_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'h1234, 4'b0000, k));
                end
            end
            checks++; if (frame_tick !== (k == 31)) begin errors++; $display("FAIL scan_ft k=%0d got %b", k, frame_tick); end
        end
    endtask

    task automatic test_anti_tear();
        logic [3:0] ea;
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = exp_an(k, 4'hF);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL tear_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'h1234, 4'b0000, k)) begin
                    errors++; $display("FAIL tear_old_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'h1234, 4'b0000, k));
                end
            end
            if (k == 18) value_in = 16'hABCD;
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = exp_an(k, 4'hF);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL tear_new_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'hABCD, 4'b0000, k)) begin
                    errors++; $display("FAIL tear_new_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'hABCD, 4'b0000, k));
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] ea;
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = (k >= 6 && k <= 25) ? 4'hF : exp_an(k, 4'hF);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL en_an k=%0d got %b exp %b", k, seg_an, ea); end
            checks++; if (frame_tick !== (k == 31)) begin errors++; $display("FAIL en_ft_period k=%0d got %b", k, frame_tick); end
            if (k == 5) en = 1'b0;
            if (k == 25) en = 1'b1;
        end
    endtask

    task automatic test_blanking();
        int n;
        logic [3:0] ea;
        value_in = 16'h0005; dp_in = 4'b0000;
        wait_frame(n);
        checks++; if (n == 0) begin errors++; $display("FAIL blank_ft_timeout got %0d exp >0", n); end
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = exp_an(k, LIT_0005);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL blank_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'h0005, 4'b0000, k)) begin
                    errors++; $display("FAIL blank_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'h0005, 4'b0000, k));
                end
            end
        end
        dp_in = 4'b0100;
        wait_frame(n);
        checks++; if (n == 0) begin errors++; $display("FAIL blank_dp_ft_timeout got %0d exp >0", n); end
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = exp_an(k, LIT_0005_DP);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL blank_dp_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'h0005, 4'b0100, k)) begin
                    errors++; $display("FAIL blank_dp_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'h0005, 4'b0100, k));
                end
            end
        end
    endtask

    task automatic test_wrap_decode();
        int n;
        logic [3:0] ea;
        value_in = 16'hF0E9; dp_in = 4'b0000;
        wait_frame(n);
        checks++; if (n == 0) begin errors++; $display("FAIL wrap_ft_timeout got %0d exp >0", n); end
        for (int k = 0; k < 40; k++) begin
            tick();
            ea = exp_an(k, 4'hF);
            checks++; if (seg_an !== ea) begin errors++; $display("FAIL wrap_an k=%0d got %b exp %b", k, seg_an, ea); end
            if (ea != 4'hF) begin
                checks++;
                if (seg_cat !== exp_cat(16'hF0E9, 4'b0000, k)) begin
                    errors++; $display("FAIL wrap_cat k=%0d got %h exp %h", k, seg_cat, exp_cat(16'hF0E9, 4'b0000, k));
                end
            end
            checks++; if (frame_tick !== (k == 31)) begin errors++; $display("FAIL wrap_ft k=%0d got %b", k, frame_tick); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int first;
        wait_frame(n);
        checks++; if (n == 0) begin errors++; $display("FAIL rmid_ft_timeout got %0d exp >0", n); end
        repeat (31) tick();
        reset = 1'b1;
        #1;
        checks++; if (seg_an !== 4'hF) begin errors++; $display("FAIL rmid_async_an got %b exp 1111", seg_an); end
        checks++; if (seg_cat !== 8'hFF) begin errors++; $display("FAIL rmid_async_cat got %h exp FF", seg_cat); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rmid_async_ft got %b exp 0", frame_tick); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse i=%0d got %b exp 0", i, frame_tick); end
        end
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) begin
                checks++; if (seg_an !== 4'hE) begin errors++; $display("FAIL rmid_an got %b exp 1110", seg_an); end
                checks++; if (seg_cat !== 8'hC0) begin errors++; $display("FAIL rmid_shadow_cat got %h exp C0", seg_cat); end
            end
            if (frame_tick === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first + 1 != 33) begin errors++; $display("FAIL rmid_first_ft cycle got %0d exp 33", first + 1); end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; value_in = 16'h0000; dp_in = 4'b0000;
        test_reset();
        test_scan();
        test_anti_tear();
        test_enable();
        test_blanking();
        test_wrap_decode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
